// File: rtl/packet_fifo_pkg.sv
// Shared types and constants for the packet FIFO writer.
package packet_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam int DEFAULT_COUNTER_WIDTH = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [width-1:0] count
);

    logic [width-1:0] count_q;
    logic [width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {width{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/packet_fifo_writer.sv
// AXI-stream to packet FIFO writer: never back-pressures, drops packets that
// start while the FIFO is almost full and truncates packets that hit it mid-way.
module packet_fifo_writer
    import packet_fifo_pkg::*;
#(
    parameter int data_width     = 256,
    parameter int metadata_width = 32,
    parameter int counter_width  = DEFAULT_COUNTER_WIDTH
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [data_width-1:0]     s_axis_tdata,
    input  logic [metadata_width-1:0] s_axis_tuser,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [data_width-1:0]     wr_data,
    output logic [metadata_width-1:0] wr_metadata,
    output logic                      wr_last,
    output logic                      wr_dirty,
    output logic                      wr,
    input  logic                      wr_full,
    input  logic                      wr_almost_full,
    output logic [counter_width-1:0]  drop_count,
    output logic [counter_width-1:0]  trunc_count,
    output logic                      overflow_error
);

    state_t                    state_q, state_d;
    logic [metadata_width-1:0] hold_q, hold_d;
    logic [data_width-1:0]     wr_data_q, wr_data_d;
    logic [metadata_width-1:0] wr_meta_q, wr_meta_d;
    logic                      wr_last_q, wr_last_d;
    logic                      wr_dirty_q, wr_dirty_d;
    logic                      wr_q, wr_d;
    logic                      ovf_q, ovf_d;
    logic                      drop_inc;
    logic                      trunc_inc;
    logic                      beat;

    assign s_axis_tready = resetn;
    assign beat          = s_axis_tvalid & resetn;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        wr_d       = 1'b0;
        wr_data_d  = wr_data_q;
        wr_meta_d  = wr_meta_q;
        wr_last_d  = wr_last_q;
        wr_dirty_d = wr_dirty_q;
        drop_inc   = 1'b0;
        trunc_inc  = 1'b0;
        ovf_d      = ovf_q | (wr_q & wr_full);
        if (beat) begin
            case (state_q)
                ST_IDLE: begin
                    if (!wr_almost_full) begin
                        wr_d       = 1'b1;
                        wr_data_d  = s_axis_tdata;
                        wr_meta_d  = s_axis_tuser;
                        hold_d     = s_axis_tuser;
                        wr_last_d  = s_axis_tlast;
                        wr_dirty_d = 1'b0;
                        state_d    = s_axis_tlast ? ST_IDLE : ST_FORWARD;
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = s_axis_tlast ? ST_IDLE : ST_DISCARD;
                    end
                end
                ST_FORWARD: begin
                    wr_d      = 1'b1;
                    wr_data_d = s_axis_tdata;
                    wr_meta_d = hold_q;
                    // A real last beat always wins over truncation.
                    if (s_axis_tlast) begin
                        wr_last_d  = 1'b1;
                        wr_dirty_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else if (wr_almost_full) begin
                        wr_last_d  = 1'b1;
                        wr_dirty_d = 1'b1;
                        trunc_inc  = 1'b1;
                        state_d    = ST_DISCARD;
                    end else begin
                        wr_last_d  = 1'b0;
                        wr_dirty_d = 1'b0;
                    end
                end
                ST_DISCARD: begin
                    if (s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            wr_q       <= 1'b0;
            wr_data_q  <= '0;
            wr_meta_q  <= '0;
            wr_last_q  <= 1'b0;
            wr_dirty_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            wr_q       <= wr_d;
            wr_data_q  <= wr_data_d;
            wr_meta_q  <= wr_meta_d;
            wr_last_q  <= wr_last_d;
            wr_dirty_q <= wr_dirty_d;
            ovf_q      <= ovf_d;
        end
    end

    sat_counter #(.width(counter_width)) u_drop_counter (
        .clk    (clk),
        .resetn (resetn),
        .inc    (drop_inc),
        .count  (drop_count)
    );

    sat_counter #(.width(counter_width)) u_trunc_counter (
        .clk    (clk),
        .resetn (resetn),
        .inc    (trunc_inc),
        .count  (trunc_count)
    );

    assign wr             = wr_q;
    assign wr_data        = wr_data_q;
    assign wr_metadata    = wr_meta_q;
    assign wr_last        = wr_last_q;
    assign wr_dirty       = wr_dirty_q;
    assign overflow_error = ovf_q;

endmodule

// File: tb/tb_packet_fifo_writer.sv
// Self-checking bench for packet_fifo_writer against a packet-level reference model.
module tb_packet_fifo_writer;

    localparam int DW = 16;
    localparam int MW = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int VW = 1 + DW + MW + 1 + 1 + CW + CW + 1 + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [MW-1:0] s_axis_tuser = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] wr_data;
    logic [MW-1:0] wr_metadata;
    logic          wr_last;
    logic          wr_dirty;
    logic          wr;
    logic          wr_full = 1'b0;
    logic          wr_almost_full = 1'b0;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] trunc_count;
    logic          overflow_error;

    int total = 0;
    int bad = 0;

    packet_fifo_writer #(
        .data_width     (DW),
        .metadata_width (MW),
        .counter_width  (CW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .wr_data        (wr_data),
        .wr_metadata    (wr_metadata),
        .wr_last        (wr_last),
        .wr_dirty       (wr_dirty),
        .wr             (wr),
        .wr_full        (wr_full),
        .wr_almost_full (wr_almost_full),
        .drop_count     (drop_count),
        .trunc_count    (trunc_count),
        .overflow_error (overflow_error)
    );

    always #5 clk = ~clk;

    // Reference model: packet-level view of what the FIFO should receive.
    bit          in_pkt = 0;
    bit          dropping = 0;
    logic [MW-1:0] held = '0;
    logic          exp_wr = 0;
    logic [DW-1:0] exp_data = '0;
    logic [MW-1:0] exp_meta = '0;
    logic          exp_last = 0;
    logic          exp_dirty = 0;
    int            exp_drop = 0;
    int            exp_trunc = 0;
    logic          exp_ovf = 0;

    wire [VW-1:0] obs_vec = {wr, wr_data, wr_metadata, wr_last, wr_dirty,
                             drop_count, trunc_count, overflow_error, s_axis_tready};
    logic [VW-1:0] exp_vec;
    always_comb begin
        exp_vec = {exp_wr, exp_data, exp_meta, exp_last, exp_dirty,
                   exp_drop[CW-1:0], exp_trunc[CW-1:0], exp_ovf, resetn};
    end

    task automatic emit(input logic [DW-1:0] d, input logic [MW-1:0] m,
                        input logic l, input logic dy);
        exp_wr = 1; exp_data = d; exp_meta = m; exp_last = l; exp_dirty = dy;
    endtask

    // Drive one cycle; model predicts the registered outputs after this edge.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [MW-1:0] u,
                         input logic l, input logic af, input logic full);
        s_axis_tvalid = v; s_axis_tdata = d; s_axis_tuser = u;
        s_axis_tlast = l; wr_almost_full = af; wr_full = full;
        if (!resetn) begin
            in_pkt = 0; dropping = 0; held = '0;
            exp_wr = 0; exp_data = '0; exp_meta = '0; exp_last = 0; exp_dirty = 0;
            exp_drop = 0; exp_trunc = 0; exp_ovf = 0;
        end else begin
            if (exp_wr && full) exp_ovf = 1;
            exp_wr = 0;
            if (v) begin
                if (!in_pkt) begin
                    in_pkt = !l;
                    if (!af) begin
                        held = u; dropping = 0;
                        emit(d, u, l, 1'b0);
                    end else begin
                        dropping = 1;
                        exp_drop = (exp_drop == CMAX) ? CMAX : exp_drop + 1;
                    end
                end else if (dropping) begin
                    if (l) in_pkt = 0;
                end else if (l) begin
                    emit(d, held, 1'b1, 1'b0);
                    in_pkt = 0;
                end else if (af) begin
                    emit(d, held, 1'b1, 1'b1);
                    exp_trunc = (exp_trunc == CMAX) ? CMAX : exp_trunc + 1;
                    dropping = 1;
                end else begin
                    emit(d, held, 1'b0, 1'b0);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'hFFFF, 8'hFF, 1'b0, 1'b0, 1'b1);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL reset cyc %0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
        resetn = 1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs_vec !== exp_vec) begin
            bad++; $display("FAIL reset_release: got %h want %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, 16'h1000 + 16'(i), (i == 0) ? 8'hA5 : 8'h3C, i == 2, 1'b0, 1'b0);
            else       drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL basic beat %0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_drop_single();
        drive(1'b1, 16'hDEAD, 8'h11, 1'b1, 1'b1, 1'b0);
        total++;
        if (obs_vec !== exp_vec || drop_count !== 4'd1) begin
            bad++; $display("FAIL drop_single: got %h want %h", obs_vec, exp_vec);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'h2000 + 16'(i), 8'h22 + 8'(i), i == 1, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL drop_then_fwd beat %0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_truncate();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(1'b1, 16'h3000 + 16'(i), 8'h40 + 8'(i), i == 4, i >= 1, 1'b0);
            else       drive(1'b1, 16'h3100, 8'h77, 1'b1, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL truncate beat %0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_af_on_last();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h4000 + 16'(i), 8'h5A, i == 2, i == 2, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL af_on_last beat %0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < CMAX + 3; i++) begin
            drive(1'b1, 16'(i), 8'(i), 1'b1, 1'b1, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL saturation pkt %0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
        total++;
        if (drop_count !== 4'hF) begin
            bad++; $display("FAIL saturation_final: got %h want f", drop_count);
        end
    endtask

    task automatic test_overflow();
        drive(1'b1, 16'h5555, 8'h66, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, i == 0);
            total++;
            if (obs_vec !== exp_vec || overflow_error !== 1'b1) begin
                bad++; $display("FAIL overflow cyc %0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 16'h6000, 8'h81, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h6001, 8'h82, 1'b0, 1'b0, 1'b0);
        resetn = 0;
        drive(1'b1, 16'h6002, 8'h83, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs_vec !== exp_vec) begin
            bad++; $display("FAIL reset_mid in_reset: got %h want %h", obs_vec, exp_vec);
        end
        resetn = 1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'h6003 + 16'(i), 8'h84 + 8'(i), i == 1, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL reset_mid tail %0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 8'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 31) == 0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL random cyc %0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_drop_single();
        test_truncate();
        test_af_on_last();
        test_saturation();
        test_overflow();
        test_reset_mid();
        test_reset();
        test_random();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
